// File: rtl/mc_timing_pkg.sv
// Shared constants for the timing/decode unit and its sequence counter.
package mc_timing_pkg;

  localparam int unsigned SC_WIDTH_DEF = 3;
  localparam int unsigned IR_WIDTH_DEF = 16;

  // Opcode decode indices (D outputs).
  localparam int unsigned OP_AND = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_LDA = 2;
  localparam int unsigned OP_STA = 3;
  localparam int unsigned OP_BUN = 4;
  localparam int unsigned OP_BSA = 5;
  localparam int unsigned OP_ISZ = 6;
  localparam int unsigned OP_REG = 7;

  // Timing indices (T outputs).
  localparam int unsigned T_FETCH0  = 0;
  localparam int unsigned T_FETCH1  = 1;
  localparam int unsigned T_DECODE2 = 2;
  localparam int unsigned T_EXEC3   = 3;
  localparam int unsigned T_EXEC4   = 4;
  localparam int unsigned T_EXEC5   = 5;
  localparam int unsigned T_EXEC6   = 6;
  localparam int unsigned T_EXEC7   = 7;

  // Register-reference field layout.
  localparam int unsigned HLT_BIT  = 0;
  localparam int unsigned B_OFFSET = 4;

  function automatic logic [7:0] onehot3(input logic [2:0] v);
    return 8'h01 << v;
  endfunction

endpackage

// File: rtl/sc_counter_clr_inr.sv
// Sequence counter with synchronous clear/increment and one-hot decode.
module sc_counter_clr_inr #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inr,
  output logic [WIDTH-1:0]      count,
  output logic [2**WIDTH-1:0]   dec
);

  // Clear has priority over increment; increment wraps naturally.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inr) begin
      count <= count + 1'b1;
    end
  end

  // One-hot decode of the registered count.
  always_comb begin
    dec = '0;
    dec[count] = 1'b1;
  end

endmodule

// File: rtl/timing_decode_unit.sv
// Run/halt flip-flop, sequence counter, T decoder and IR field decode.
// Optional SC overrun detection is enabled by defining SC_WRAP_CHECK_EN.
module timing_decode_unit
  import mc_timing_pkg::*;
#(
  parameter int unsigned SC_WIDTH = SC_WIDTH_DEF,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [IR_WIDTH-1:0]    ir,
  input  logic                   clr_sc,
  output logic [2**SC_WIDTH-1:0] T,
  output logic [7:0]             D,
  output logic                   I,
  output logic [7:0]             B,
  output logic                   running,
  output logic                   sc_wrap_err
);

  logic [SC_WIDTH-1:0]   sc;
  logic [2**SC_WIDTH-1:0] sc_dec;
  logic                  halt;
  logic                  sc_clr;
  logic                  unused_ir;

  // Counter only advances while running; halt and idle both force zero.
  assign sc_clr = halt | clr_sc | ~running;

  sc_counter_clr_inr #(
    .WIDTH (SC_WIDTH)
  ) u_sc (
    .clk   (clk),
    .rst   (rst),
    .clr   (sc_clr),
    .inr   (running),
    .count (sc),
    .dec   (sc_dec)
  );

  // Timing, opcode and register-reference decode.
  always_comb begin
    T    = running ? sc_dec : '0;
    D    = onehot3(ir[14:12]);
    B    = ir[B_OFFSET +: 8];
    halt = running & T[T_EXEC3] & D[OP_REG] & ~I & ir[HLT_BIT];
  end

  assign unused_ir = ^ir[3:1];

  // Run flip-flop: halt beats a simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
    end else if (halt) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
    end
  end

  // Indirect flip-flop captured at the end of T2.
  always_ff @(posedge clk) begin
    if (rst) begin
      I <= 1'b0;
    end else if (running && (sc == SC_WIDTH'(T_DECODE2))) begin
      I <= ir[15];
    end
  end

`ifdef SC_WRAP_CHECK_EN
  // Sticky flag: the control unit let SC run past T7.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_wrap_err <= 1'b0;
    end else if (running && (sc == SC_WIDTH'(T_EXEC7)) && !clr_sc) begin
      sc_wrap_err <= 1'b1;
    end
  end
`else
  assign sc_wrap_err = 1'b0;
`endif

endmodule

// File: doc/timing_decode_unit.md
Name: timing_decode_unit

Overview:
- Upstream neighbour of the control unit.
- Owns the run/halt flip-flop, the 3-bit sequence counter (SC), and the T timing decoder.
- Decodes the instruction register into D (opcode), I (indirect flip-flop) and B (register-reference bits).
- Produces exactly the T[7:0], D[7:0], I and B[7:0] the control unit consumes, and accepts its CLRSC back.

Parameters:
- SC_WIDTH, 3, sequence counter width; T width is 2**SC_WIDTH (8).
- IR_WIDTH, 16, instruction register width; opcode is ir[14:12], indirect bit is ir[15].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that sets the run flip-flop.
- ir  input  16  current instruction register contents.
- clr_sc  input  1  CLRSC from the control unit; clears SC at the next edge.
- T  output  8  one-hot timing signals T0..T7; all zero while halted.
- D  output  8  one-hot opcode decode of ir[14:12].
- I  output  1  indirect flip-flop.
- B  output  8  register-reference bits; B[k] = ir[k+4], so B[7] = ir[11] and B[0] = ir[4].
- running  output  1  run flip-flop S.
- sc_wrap_err  output  1  sticky SC-overrun flag; tied 0 when the optional feature is absent.

Behaviour:
- Reset values (rst high at an edge): sc=0, S=0, I=0, sc_wrap_err=0. Outputs after reset: T=8'h00, running=0. D and B follow ir combinationally.
- Reset has priority over every other input, including mid-instruction.
- S flip-flop:
  - start=1 with S=0 sets S=1 at the edge; sc stays 0, so T0 asserts in the first running cycle.
  - start while S=1 is ignored.
- Halt condition: S & T[3] & D[7] & ~I & ir[0] (HLT register-reference).
  - At that edge: S<=0 and sc<=0.
  - Halt wins over a simultaneous start.
- SC update while S=1, in priority order:
  - clr_sc=1: sc<=0.
  - otherwise: sc<=sc+1, modulo 2**SC_WIDTH, so 7 wraps to 0.
- SC while S=0: holds 0; clr_sc has no effect.
- T = S ? onehot(sc) : 0. Combinational from registered sc, so no added latency: T_k is high in the cycle when sc==k.
- D = onehot(ir[14:12]), combinational, always valid regardless of S.
- I flip-flop:
  - Loads ir[15] at the edge ending a T2 cycle (S & sc==2).
  - Otherwise holds, so it is valid from T3 to the end of the instruction.
- B: pure wiring from ir.
- Simultaneous clr_sc and a halt edge: both clear sc to 0; S<=0 from the halt.

Optional Feature:
- Macro: SC_WRAP_CHECK_EN.
- Defined: sc_wrap_err is set at any edge where S=1, sc==7 and clr_sc=0 (the control unit failed to end the instruction). It is sticky until rst.
- Undefined: sc_wrap_err is constant 0 and no extra flop exists. The 7 to 0 wrap still occurs silently.

Decomposition:
- Shared package (mc_timing_pkg) holds:
  - SC_WIDTH and IR_WIDTH defaults.
  - Opcode index constants: OP_AND=0, OP_ADD=1, OP_LDA=2, OP_STA=3, OP_BUN=4, OP_BSA=5, OP_ISZ=6, OP_REG=7.
  - Timing index constants T_FETCH0..T_EXEC7.
  - HLT_BIT=0 and the B offset (4).
- One sub-module: sc_counter_clr_inr. Synchronous clear/increment counter with enable, plus its one-hot decoder. Instantiated once.
- The S/I flip-flops and opcode decode stay in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 for 5 cycles -> T=8'h00, running=0, sc held 0.
- Start and free-run: start pulse, clr_sc=0 -> T steps 01,02,04,...,80 over 8 cycles, then wraps to 01. With SC_WRAP_CHECK_EN, sc_wrap_err=1 from the cycle after T7.
- Instruction clear: start, then clr_sc=1 during T4 -> next cycle T=8'h01. No sc_wrap_err.
- Indirect capture: ir=16'hA123 held from T0 -> I=0 through T2, I=1 from T3. D=8'h04 (opcode 2) throughout.
- Halt: ir=16'h7001, run to T3 -> at the next edge running=0 and T=8'h00. start=1 together with that halt edge -> stays halted. A later lone start -> T0 in the following cycle.
- Reset mid-instruction: rst=1 during T5 with I=1 -> next cycle sc=0, S=0, I=0, sc_wrap_err=0, T=8'h00.
